// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer between two command decoders and the shared 4-bit ALU.
// Optional result flags (resp_zero/resp_carry) are built only when ALU_ARB_FLAGS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a request; winner gets combinational ready and is latched
// EXEC    | ALU driven from operand registers; result captured at the edge
// DONE    | response valid, held until resp_ready
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic             resp_zero,
  output logic             resp_carry
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  if (WIDTH != 4) begin : g_width_check
    $error("alu_arbiter: only WIDTH=4 matches the shared ALU");
  end

  logic [1:0]       state;
  logic             last_grant;
  logic             op_id;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic             any_valid;
  logic             grant_id;
  logic             accept;
  logic [1:0]       grant_op;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept    = rst_n & (state == ST_IDLE) & any_valid;
    grant_op  = grant_id ? req1_op : req0_op;
    grant_a   = grant_id ? req1_a  : req0_a;
    grant_b   = grant_id ? req1_b  : req0_b;
  end

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (any_valid)  state <= ST_EXEC;
        ST_EXEC:                 state <= ST_DONE;
        ST_DONE: if (resp_ready) state <= ST_IDLE;
        default:                 state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_code    <= 2'b00;
      op_a       <= '0;
      op_b       <= '0;
    end else if (accept) begin
      last_grant <= grant_id;
      op_id      <= grant_id;
      op_code    <= grant_op;
      op_a       <= grant_a;
      op_b       <= grant_b;
    end
  end

  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id   <= 1'b0;
      resp_data <= '0;
    end else if (state == ST_EXEC) begin
      resp_id   <= op_id;
      resp_data <= alu_out;
    end
  end

  assign resp_valid = (state == ST_DONE);

`ifdef ALU_ARB_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic           carry_next;

  // Carry comes from the latched operands, not the ALU, so it does not depend on ALU internals.
  always_comb begin
    sum_ext = {1'b0, op_a} + {1'b0, op_b};
    case (op_code)
      OP_ADD:  carry_next = sum_ext[WIDTH];
      OP_SUB:  carry_next = (op_a < op_b);
      default: carry_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_zero  <= 1'b0;
      resp_carry <= 1'b0;
    end else if (state == ST_EXEC) begin
      resp_zero  <= (alu_out == '0);
      resp_carry <= carry_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: provides the ALU, a spec-level reference model and directed tests.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_op;
  logic       resp_valid, resp_id, resp_ready;
  logic [3:0] resp_data;
  logic       resp_zero, resp_carry;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready)
`ifdef ALU_ARB_FLAGS_EN
    , .resp_zero(resp_zero), .resp_carry(resp_carry)
`endif
  );

`ifndef ALU_ARB_FLAGS_EN
  assign resp_zero  = 1'b0;
  assign resp_carry = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  function automatic logic carry_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      2'b10:   return s[4];
      2'b11:   return (a < b);
      default: return 1'b0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one operation in flight; result appears the cycle after acceptance
  // and is held until consumed.
  logic       m_idle, m_exec, m_last, m_id;
  logic [1:0] m_op;
  logic [3:0] m_a, m_b;
  logic       m_rv, m_rid, m_rz, m_rc;
  logic [3:0] m_rd;
  logic       m_win;

  assign m_win = (req0_valid && req1_valid) ? !m_last : req1_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_exec <= 1'b0; m_last <= 1'b1; m_id <= 1'b0;
      m_op <= 2'b00; m_a <= 4'h0; m_b <= 4'h0;
      m_rv <= 1'b0; m_rid <= 1'b0; m_rd <= 4'h0; m_rz <= 1'b0; m_rc <= 1'b0;
    end else if (m_idle) begin
      if (req0_valid || req1_valid) begin
        m_id   <= m_win;
        m_last <= m_win;
        m_op   <= m_win ? req1_op : req0_op;
        m_a    <= m_win ? req1_a  : req0_a;
        m_b    <= m_win ? req1_b  : req0_b;
        m_idle <= 1'b0;
        m_exec <= 1'b1;
      end
    end else if (m_exec) begin
      m_rd   <= alu_f(m_op, m_a, m_b);
      m_rz   <= (alu_f(m_op, m_a, m_b) == 4'h0);
      m_rc   <= carry_f(m_op, m_a, m_b);
      m_rid  <= m_id;
      m_rv   <= 1'b1;
      m_exec <= 1'b0;
    end else if (resp_ready) begin
      m_rv   <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  typedef struct packed {logic id; logic [3:0] data; logic z; logic c;} resp_t;
  resp_t resp_log[$];

  always @(negedge clk) begin
    logic busy_free;
    busy_free = rst_n && m_idle && (req0_valid || req1_valid);
    chk("req0_ready", req0_ready, busy_free && !m_win);
    chk("req1_ready", req1_ready, busy_free && m_win);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_id", resp_id, m_rid);
    chk("resp_data", resp_data, m_rd);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
`ifdef ALU_ARB_FLAGS_EN
    chk("resp_zero", resp_zero, m_rz);
    chk("resp_carry", resp_carry, m_rc);
`endif
    if (resp_valid && resp_ready)
      resp_log.push_back('{id: resp_id, data: resp_data, z: resp_zero, c: resp_carry});
  end

  task automatic send(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input string name);
    logic got;
    int   n;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    got = 1'b0;
    n   = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: ready never seen within 60 cycles", name);
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic expect_resp(input logic id, input logic [3:0] data, input logic z, input logic c,
                             input string name);
    int    n;
    resp_t r;
    n = 0;
    while (resp_log.size() == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (resp_log.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no response within 40 cycles", name);
    end else begin
      r = resp_log.pop_front();
      chk({name, "_id"}, r.id, id);
      chk({name, "_data"}, r.data, data);
`ifdef ALU_ARB_FLAGS_EN
      chk({name, "_zero"}, r.z, z);
      chk({name, "_carry"}, r.c, c);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = 4'h0; req0_b = 4'h0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = 4'h0; req1_b = 4'h0;

    // Reset values, with a request present to show ready stays low in reset
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    #2;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 4'h0);
    chk("rst_alu_op", alu_op, 2'b00);
    req0_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(1'b0, 2'b10, 4'h7, 4'h5, "t1_send");
    expect_resp(1'b0, 4'hC, 1'b0, 1'b0, "t1_add");

    send(1'b1, 2'b11, 4'h3, 4'h5, "t2_send");
    expect_resp(1'b1, 4'hE, 1'b0, 1'b1, "t2_sub");

    // Both requesters contend from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        send(1'b0, 2'b00, 4'hC, 4'hA, "t3_and");
        send(1'b0, 2'b10, 4'hF, 4'h1, "t3_add");
      end
      begin
        send(1'b1, 2'b01, 4'hC, 4'hA, "t3_or");
        send(1'b1, 2'b11, 4'h4, 4'h4, "t3_sub");
      end
    join
    expect_resp(1'b0, 4'h8, 1'b0, 1'b0, "t3_r0");
    expect_resp(1'b1, 4'hE, 1'b0, 1'b0, "t3_r1");
    expect_resp(1'b0, 4'h0, 1'b1, 1'b1, "t3_r2");
    expect_resp(1'b1, 4'h0, 1'b1, 1'b0, "t3_r3");

    // Consumer stall in DONE while req1 waits
    resp_ready = 1'b0;
    send(1'b0, 2'b01, 4'h1, 4'h2, "t4_send0");
    fork
      send(1'b1, 2'b00, 4'hF, 4'h3, "t4_send1");
      begin
        n = 0;
        while (!resp_valid && n < 10) begin
          @(posedge clk); #1;
          n++;
        end
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_valid", resp_valid, 1'b1);
          chk("t4_stall_data", resp_data, 4'h3);
          chk("t4_stall_req1_ready", req1_ready, 1'b0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
      end
    join
    expect_resp(1'b0, 4'h3, 1'b0, 1'b0, "t4_r0");
    expect_resp(1'b1, 4'h3, 1'b0, 1'b0, "t4_r1");

    // Reset during EXEC discards the operation
    send(1'b0, 2'b01, 4'h3, 4'h4, "t5_send0");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_resp_valid", resp_valid, 1'b0);
    chk("t5_rst_resp_id", resp_id, 1'b0);
    chk("t5_rst_resp_data", resp_data, 4'h0);
    chk("t5_rst_alu_a", alu_a, 4'h0);
    chk("t5_rst_alu_b", alu_b, 4'h0);
    chk("t5_rst_alu_op", alu_op, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_no_resp", resp_log.size(), 0);
    fork
      send(1'b1, 2'b10, 4'h2, 4'h3, "t5_send1");
      begin
        @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    fork
      send(1'b0, 2'b11, 4'h9, 4'h2, "t5_tie0");
      send(1'b1, 2'b01, 4'h1, 4'h8, "t5_tie1");
    join
    expect_resp(1'b1, 4'h5, 1'b0, 1'b0, "t5_r0");
    expect_resp(1'b0, 4'h7, 1'b0, 1'b0, "t5_r1");
    expect_resp(1'b1, 4'h9, 1'b0, 1'b0, "t5_r2");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
